edge_result_writer: RTL



---
 rtl/edge_result_writer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/edge_result_writer.sv
// edge_result_writer: captures the processed pixel stream into a small FIFO and drains it
// to memory over an Avalon-MM write master, one byte per transfer, at base + pixel index.
// Optional build macro EDGE_RESULT_WRITER_THRESHOLD_EN binarises each pixel against THRESHOLD at push.
//
// Handshakes:
//   - Pixel input: valid_i has no back-pressure. A beat is accepted in RUN only while fewer
//     than NUM_PIXELS beats have arrived.
//   - Write master: a transfer completes on the cycle where avm_write_o=1 and
//     avm_waitrequest_i=0. Address and data hold steady while waitrequest is high.
module edge_result_writer #(
  parameter int NUM_PIXELS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int THRESHOLD  = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  valid_i,
  input  logic [7:0]            ProcessedImagePixel_i,
  output logic [ADDR_WIDTH-1:0] avm_address_o,
  output logic                  avm_write_o,
  output logic [7:0]            avm_writedata_o,
  input  logic                  avm_waitrequest_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [1:0]            state_o
);

  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         rx_count;
  logic [CW-1:0]         rx_next;
  logic [CW-1:0]         fifo_idx [FIFO_DEPTH];
  logic [7:0]            fifo_pix [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [PW:0]           count_next;
  logic                  empty;
  logic                  full;
  logic                  beat;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [7:0]            pix_in;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(FIFO_DEPTH));

  // A full FIFO still accepts a beat when the head is leaving on the same edge.
  assign beat       = (state == S_RUN) && valid_i && (rx_count < CW'(NUM_PIXELS));
  assign pop        = avm_write_o && !avm_waitrequest_i;
  assign push       = beat && (!full || pop);
  assign drop       = beat && !push;
  assign rx_next    = beat ? rx_count + CW'(1) : rx_count;
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

`ifdef EDGE_RESULT_WRITER_THRESHOLD_EN
  assign pix_in = (int'(ProcessedImagePixel_i) >= THRESHOLD) ? 8'hFF : 8'h00;
`else
  assign pix_in = ProcessedImagePixel_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      base_q     <= '0;
      rx_count   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state      <= S_RUN;
            base_q     <= base_addr_i;
            rx_count   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
          end
        end
        S_RUN: begin
          rx_count <= rx_next;
          count    <= count_next;
          if (push) begin
            fifo_idx[wr_ptr] <= rx_count;
            fifo_pix[wr_ptr] <= pix_in;
            wr_ptr           <= wr_ptr + PW'(1);
          end
          if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
          end
          if (drop) begin
            overflow_o <= 1'b1;
          end
          // Finish on the edge that retires the last write, so done_o follows it directly.
          if ((rx_next == CW'(NUM_PIXELS)) && (count_next == '0)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign avm_write_o     = (state == S_RUN) && !empty;
  assign avm_address_o   = avm_write_o ? base_q + ADDR_WIDTH'(fifo_idx[rd_ptr]) : '0;
  assign avm_writedata_o = avm_write_o ? fifo_pix[rd_ptr] : 8'h00;
  assign busy_o          = (state == S_RUN);
  assign done_o          = (state == S_DONE);
  assign state_o         = state;

endmodule
